// File: rtl/mux4_1_df_pkg.sv
// Select encoding shared by the datapath steering muxes.
// The code is {s1,s0}, with s1 as the MSB.
package mux4_1_df_pkg;

    localparam logic [1:0] SEL_I0 = 2'd0;
    localparam logic [1:0] SEL_I1 = 2'd1;
    localparam logic [1:0] SEL_I2 = 2'd2;
    localparam logic [1:0] SEL_I3 = 2'd3;

    function automatic logic [1:0] sel_code(input logic s1, input logic s0);
        return {s1, s0};
    endfunction

endpackage

// File: rtl/mux4_1_df.sv
// 4:1 data-flow multiplexer with a combinational result and a registered copy.
// The registered copy is cleared asynchronously.
module mux4_1_df
    import mux4_1_df_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y_q
);

    // Nested ?: keeps X-merge behaviour on an unknown select: bits where inputs agree survive.
    assign y = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y;
        end
    end

endmodule

// File: tb/tb_mux4_1_df.sv
// Self-checking bench for mux4_1_df: directed vectors plus a per-cycle model comparison.
module tb_mux4_1_df;

    logic i0, i1, i2, i3, s1, s0;
    logic y, y_q;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int failures = 0;
    bit run_compare = 1'b0;
    logic exp_q = 1'b0;

    mux4_1_df #(.WIDTH(1)) dut (
        .i0  (i0),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .s1  (s1),
        .s0  (s0),
        .y   (y),
        .clk (clk),
        .rst (rst),
        .y_q (y_q)
    );

    always #5 clk = ~clk;

    // Reference: select index is 2*s1 + s0 into the data array.
    function automatic logic ref_y(input logic a0, input logic a1, input logic a2,
                                   input logic a3, input logic b1, input logic b0);
        logic d [4];
        int idx;
        d[0] = a0; d[1] = a1; d[2] = a2; d[3] = a3;
        idx = 2 * int'(b1) + int'(b0);
        return d[idx];
    endfunction

    task automatic check(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b at t=%0t", name, got, want, $time);
        end
    endtask

    // Registered-copy expectation: value of y seen at the last rising edge, zero while reset is high.
    always @(posedge clk) begin
        if (rst) exp_q = 1'b0;
        else     exp_q = ref_y(i0, i1, i2, i3, s1, s0);
    end
    always @(posedge rst) exp_q = 1'b0;

    always @(negedge clk) begin
        if (run_compare) begin
            check("cyc_y", y, ref_y(i0, i1, i2, i3, s1, s0));
            check("cyc_y_q", y_q, exp_q);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        i0 = 1'b0; i1 = 1'b1; i2 = 1'b1; i3 = 1'b0;
        s1 = 1'b0; s0 = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("reset_y_q_no_edge", y_q, 1'b0);
        run_compare = 1'b1;

        // Select sweep with i0=0 i1=1 i2=1 i3=0
        step(); s1 = 1'b0; s0 = 1'b0; #5; check("sel00", y, 1'b0);
        step(); s1 = 1'b0; s0 = 1'b1; #5; check("sel01", y, 1'b1);
        step(); s1 = 1'b1; s0 = 1'b0; #5; check("sel10", y, 1'b1);
        step(); s1 = 1'b1; s0 = 1'b1; #5; check("sel11", y, 1'b0);

        // Select order: s1 is the MSB
        step(); i1 = 1'b0; i2 = 1'b1; s1 = 1'b1; s0 = 1'b0; #5;
        check("sel_order_i2", y, 1'b1);
        step(); i1 = 1'b1; i2 = 1'b0; #5;
        check("sel_order_i2_low", y, 1'b0);

        // Data tracking on i3, others must not disturb y
        step(); s1 = 1'b1; s0 = 1'b1; i3 = 1'b0; #5; check("track_i3_0", y, 1'b0);
        i3 = 1'b1; #0; check("track_i3_rise_zero_lat", y, 1'b1);
        #2; i3 = 1'b0; #1; check("track_i3_fall", y, 1'b0);
        step(); i0 = 1'b1; i1 = 1'b0; i2 = 1'b1; #5; check("track_other_a", y, 1'b0);
        step(); i0 = 1'b0; i1 = 1'b1; i2 = 1'b0; #5; check("track_other_b", y, 1'b0);

        // Reset release with {s1,s0}=01, i1=1
        step(); rst = 1'b1; s1 = 1'b0; s0 = 1'b1; i1 = 1'b1; #1;
        check("rst_hold_y_q", y_q, 1'b0);
        check("rst_y_unaffected", y, 1'b1);
        step(); rst = 1'b0; #1;
        check("rel_before_edge", y_q, 1'b0);
        @(posedge clk); #1;
        check("rel_after_edge", y_q, 1'b1);

        // Async reset mid-cycle
        #2 rst = 1'b1; #1;
        check("mid_rst_y_q", y_q, 1'b0);
        check("mid_rst_y", y, 1'b1);
        step(); rst = 1'b0;

        // Exhaustive sweep of all 64 input combinations
        for (int v = 0; v < 64; v++) begin
            logic [5:0] bits;
            bits = 6'(v);
            step();
            {i3, i2, i1, i0, s1, s0} = bits;
            #5;
            check("exhaustive", y, ref_y(bits[2], bits[3], bits[4], bits[5], bits[1], bits[0]));
        end

        step();
        run_compare = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
